// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus-ownership arbiter.
// Holds the grant for a whole cyc so that locked bursts stay with one master.
// A watchdog aborts stalled cycles and blocks the offender until it drops cyc.
module wb_rr_arbiter #(
    parameter  int NUM_MASTERS    = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_MASTERS-1:0] i_cyc,
    input  logic [NUM_MASTERS-1:0] i_stb,
    input  logic                   i_slv_ack,
    input  logic                   i_slv_err,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [IDX_W-1:0]       o_gnt_idx,
    output logic                   o_gnt_valid,
    output logic                   o_timeout_err,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        ABORT
    } state_t;

    localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       wd_q, wd_d;
    logic [NUM_MASTERS-1:0] block_q, block_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   resp;
    logic                   stall;

    // State and datapath registers; reset drops any grant at the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            wd_q    <= '0;
            block_q <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            block_q <= block_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: round-robin pick in IDLE, hold/watchdog in OWNED, one-cycle ABORT.
    always_comb begin
        req     = i_cyc & i_stb & ~block_q;
        own_cyc = i_cyc[last_q];
        own_stb = i_stb[last_q];
        resp    = i_slv_ack | i_slv_err;
        stall   = own_stb & ~resp;

        // Search starts just after the last owner and wraps; first hit wins.
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((32'(last_q) + k) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        // A block is released on any edge where that master has dropped cyc.
        block_d = block_q & i_cyc;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                wd_d  = '0;
                if (found) begin
                    state_d    = OWNED;
                    last_d     = sel;
                    idx_d      = sel;
                    gnt_d[sel] = 1'b1;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    wd_d    = '0;
                end else if (WD_EN && stall && (wd_q == WD_LIMIT)) begin
                    // Grant stays visible through ABORT so the err routes to the owner.
                    state_d         = ABORT;
                    block_d[last_q] = 1'b1;
                    wd_d            = '0;
                end else if (WD_EN && stall) begin
                    wd_d = wd_q + CNT_W'(1);
                end else begin
                    wd_d = '0;
                end
            end
            ABORT: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                wd_d    = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                wd_d    = '0;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        o_gnt         = gnt_q;
        o_gnt_idx     = idx_q;
        o_gnt_valid   = |gnt_q;
        o_timeout_err = (state_q == ABORT);
        o_busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (2 masters, 4-cycle watchdog).
// Stimulus rows: {cyc[1:0], stb[1:0], ack, err, expected gnt[1:0], expected timeout_err}
// where the expectation applies to the outputs right after that row's clock edge.
module tb_wb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cyc = '0;
    logic [1:0] stb = '0;
    logic       slv_ack = 1'b0;
    logic       slv_err = 1'b0;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       gnt_valid;
    logic       timeout_err;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [5:0] exp_q[$];

    wb_rr_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cyc        (cyc),
        .i_stb        (stb),
        .i_slv_ack    (slv_ack),
        .i_slv_err    (slv_err),
        .o_gnt        (gnt),
        .o_gnt_idx    (gnt_idx),
        .o_gnt_valid  (gnt_valid),
        .o_timeout_err(timeout_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Full observable output word: {gnt, idx, valid, timeout_err, busy}.
    function automatic logic [5:0] obs();
        return {gnt, gnt_idx, gnt_valid, timeout_err, busy};
    endfunction

    // Expected output word for a given grant and error pulse; idx/valid/busy follow the grant.
    function automatic logic [5:0] exp_vec(input logic [1:0] g, input logic t);
        return {g, g[1], |g, t, |g};
    endfunction

    task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic a, input logic e);
        cyc     = c;
        stb     = s;
        slv_ack = a;
        slv_err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] e, got;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_vec(2'b00, 1'b0));
            drive(2'b11, 2'b11, 1'b0, 1'b0);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, got, e);
            end
        end
        rst_n = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        logic [8:0] rows [5];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b01_01_0_0_01_0, 9'b01_01_0_0_01_0, 9'b01_01_1_0_01_0,
                 9'b00_00_0_0_00_0, 9'b00_00_0_0_00_0};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL single row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_tie();
        logic [8:0] rows [6];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b11_11_0_0_01_0, 9'b11_11_1_0_01_0, 9'b10_10_0_0_00_0,
                 9'b10_10_0_0_10_0, 9'b10_10_1_0_10_0, 9'b00_00_0_0_00_0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL tie row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_fairness();
        logic [8:0] rows[$];
        logic [1:0] oh;
        logic [5:0] e, got;
        do_reset();
        // Each transaction: arbitrate, one acked beat, owner drops cyc for a cycle.
        for (int t = 0; t < 8; t++) begin
            oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            rows.push_back({2'b11, 2'b11, 1'b0, 1'b0, oh, 1'b0});
            rows.push_back({2'b11, 2'b11, 1'b1, 1'b0, oh, 1'b0});
            rows.push_back({~oh, ~oh, 1'b0, 1'b0, 2'b00, 1'b0});
        end
        for (int i = 0; i < rows.size(); i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL fairness txn%0d row%0d got=%b exp=%b", i / 3, i, got, e);
            end
        end
    endtask

    task automatic test_burst();
        logic [8:0] rows [9];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b10_10_0_0_10_0, 9'b11_11_1_0_10_0, 9'b11_11_1_0_10_0,
                 9'b11_11_1_0_10_0, 9'b11_11_1_0_10_0, 9'b01_01_0_0_00_0,
                 9'b01_01_0_0_01_0, 9'b01_01_1_0_01_0, 9'b00_00_0_0_00_0};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL burst row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [8:0] rows [14];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b01_01_0_0_01_0, 9'b11_11_0_0_01_0, 9'b11_11_0_0_01_0,
                 9'b11_11_0_0_01_0, 9'b11_11_0_0_01_1, 9'b11_11_0_0_00_0,
                 9'b11_11_0_0_10_0, 9'b11_11_1_0_10_0, 9'b01_01_0_0_00_0,
                 9'b01_01_0_0_00_0, 9'b00_00_0_0_00_0, 9'b01_01_0_0_01_0,
                 9'b01_01_1_0_01_0, 9'b00_00_0_0_00_0};
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL watchdog row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_abort_drop();
        logic [8:0] rows [9];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b01_01_0_0_01_0, 9'b01_01_0_0_01_0, 9'b01_01_0_0_01_0,
                 9'b01_01_0_0_01_0, 9'b01_01_0_0_01_1, 9'b00_00_0_0_00_0,
                 9'b01_01_0_0_01_0, 9'b01_01_1_0_01_0, 9'b00_00_0_0_00_0};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL abort_drop row%0d got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_threshold_reset();
        logic [8:0] rows [10];
        logic [5:0] e, got;
        do_reset();
        rows = '{9'b01_01_0_0_01_0, 9'b11_11_0_0_01_0, 9'b11_11_0_0_01_0,
                 9'b11_11_0_0_01_0, 9'b11_11_1_0_01_0, 9'b11_11_0_0_01_0,
                 9'b11_11_0_0_01_0, 9'b11_11_0_0_01_0, 9'b11_11_0_1_01_0,
                 9'b11_11_0_0_01_0};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_vec(rows[i][2:1], rows[i][0]));
            drive(rows[i][8:7], rows[i][6:5], rows[i][4], rows[i][3]);
            e = exp_q.pop_front();
            got = obs();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL threshold row%0d got=%b exp=%b", i, got, e);
            end
        end
        // Reset while master 0 owns the bus: everything drops at that edge.
        rst_n = 1'b0;
        exp_q.push_back(exp_vec(2'b00, 1'b0));
        drive(2'b11, 2'b11, 1'b0, 1'b0);
        e = exp_q.pop_front();
        got = obs();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL rst_mid got=%b exp=%b", got, e);
        end
        // Pointer is back to its reset value, so master 0 wins the tie.
        rst_n = 1'b1;
        exp_q.push_back(exp_vec(2'b01, 1'b0));
        drive(2'b11, 2'b11, 1'b0, 1'b0);
        e = exp_q.pop_front();
        got = obs();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL rst_rearb got=%b exp=%b", got, e);
        end
        drive(2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_burst();
        test_watchdog();
        test_abort_drop();
        test_threshold_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin bus-ownership arbiter for the shared Wishbone slave side (BRAM, DMA CSR). It arbitrates between NUM_MASTERS requesters (CPU, DMA, later additions) and holds the grant for a whole Wishbone cycle (cyc high), allowing locked multi-beat bursts. A watchdog aborts stalled cycles. Its one-hot grant drives the interconnect's master mux and response routing, replacing the fixed-priority, latch-based lock.

Parameters:
NUM_MASTERS, 2, number of requesting masters (index 0 = CPU, 1 = DMA).
TIMEOUT_CYCLES, 255, stalled cycles tolerated before abort; 0 disables the watchdog.
IDX_W, $clog2(NUM_MASTERS) (min 1), width of the grant index (derived; do not override).
CNT_W, $clog2(TIMEOUT_CYCLES+1) (min 1), watchdog counter width (derived).

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst_n  input  1  synchronous active-low reset.
i_cyc  input  NUM_MASTERS  per-master Wishbone cyc.
i_stb  input  NUM_MASTERS  per-master Wishbone stb.
i_slv_ack  input  1  ack from the currently addressed slave (already muxed).
i_slv_err  input  1  err from the currently addressed slave (already muxed).
o_gnt  output  NUM_MASTERS  one-hot grant, registered.
o_gnt_idx  output  IDX_W  index of the granted master; valid when o_gnt_valid.
o_gnt_valid  output  1  some master holds the bus (o_gnt != 0).
o_timeout_err  output  1  one-cycle pulse; interconnect returns it as err to the granted master.
o_busy  output  1  state != IDLE.

Behaviour:
- Reset (i_rst_n low at edge): state = IDLE; o_gnt = 0; o_gnt_idx = 0; o_gnt_valid = 0; o_timeout_err = 0; watchdog = 0; block mask = 0; last-owner pointer = NUM_MASTERS-1, so master 0 wins first. Reset mid-ownership drops the grant at that same edge.
- Request: req[i] = i_cyc[i] & i_stb[i] & ~block[i].
- States: IDLE, OWNED, ABORT.
- IDLE: if any req, select the first requester searching from last+1 upward, wrapping modulo NUM_MASTERS. At the next edge: OWNED; o_gnt = onehot(sel); o_gnt_idx = sel; last = sel; watchdog = 0. Latency from request to grant is exactly 1 cycle. With no req, stay in IDLE with outputs at 0.
- OWNED, owner o:
  - i_cyc[o] == 0 → IDLE at next edge, grant cleared. Arbitration resumes in IDLE, so there is a minimum 1-cycle bus-idle gap between owners.
  - Otherwise the grant is held. The grant is never preempted by another requester while cyc stays high.
  - Watchdog: clears to 0 on any cycle with i_slv_ack|i_slv_err or i_stb[o] == 0. It increments on each cycle with i_stb[o] high and no ack/err.
  - If the watchdog == TIMEOUT_CYCLES-1, the current cycle is stalled, and TIMEOUT_CYCLES != 0 → ABORT at next edge.
  - ack/err in the same cycle as the threshold: ack/err wins, no abort.
- ABORT (exactly 1 cycle): o_timeout_err = 1; o_gnt/o_gnt_idx still show the owner, so the err routes correctly; block[o] set. Next edge → IDLE, grant cleared.
- Block mask: block[i] clears on any edge where i_cyc[i] == 0. An aborted master cannot be re-granted until it drops cyc. Other masters arbitrate normally meanwhile.
- o_gnt is always one-hot or zero. o_gnt_valid = |o_gnt.
- i_cyc[o] dropping during ABORT: still exactly one err pulse, then IDLE.
- NUM_MASTERS = 1: degenerates to grant/release plus watchdog; the pointer is always 0.

Test Plan:
- Single request: i_cyc/i_stb[0] = 1 at cycle 1 → o_gnt = 2'b01, o_gnt_idx = 0 at cycle 2. Ack at cycle 3, cyc low at cycle 4 → o_gnt = 0 at cycle 5.
- Post-reset tie: both masters request on the first cycle after reset → master 0 granted first. After master 0's single-beat cycle completes, master 1 is granted 1 idle cycle later.
- Round-robin fairness: both masters issue back-to-back single-beat cycles for 8 transactions → grant sequence 0,1,0,1,0,1,0,1 with no starvation.
- Burst lock: master 1 holds cyc for 4 acked beats while master 0 requests continuously → o_gnt stays 2'b10 for all 4 beats. Master 0 is granted 2 cycles after master 1 drops cyc.
- Watchdog abort and block: TIMEOUT_CYCLES = 4, master 0 granted at cycle g, no ack → o_timeout_err = 1 only at cycle g+4 with o_gnt = 01. Grant is 0 at g+5. Master 0 is not re-granted while cyc stays high; a pending master 1 is granted at g+6.
- Ack on threshold, then reset: ack arrives exactly at watchdog == 3 (TIMEOUT_CYCLES = 4) → no o_timeout_err. Reset asserted mid-OWNED → all outputs 0 at that edge, and master 0 wins the next arbitration.
